// File: rtl/rv_pkg.sv
// Shared constants and FSM state encoding for the multi-port register file.
package rv_pkg;

    localparam int unsigned XLEN_DEF  = 32;
    localparam int unsigned NREGS_DEF = 32;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_READY = 1'b1
    } rf_state_e;

endpackage

// File: rtl/regfile_sb.sv
// Pending-write scoreboard: one bit per register, set by claims, cleared by
// committed writes, with optional same-cycle clear forwarding on the lookups.
module regfile_sb
    import rv_pkg::*;
#(
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned IW    = $clog2(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          busy,
    input  logic          wr_v,
    input  logic [IW-1:0] wr_idx,
    input  logic          claim_v,
    input  logic [IW-1:0] claim_idx,
    input  logic [IW-1:0] rs1_idx,
    input  logic [IW-1:0] rs2_idx,
    output logic          rs1_pend,
    output logic          rs2_pend
);

    logic [NREGS-1:0] pend_q;
    logic [NREGS-1:0] pend_d;
    logic [NREGS-1:0] fwd_clr;

    // Claim is applied after the write clear so a same-cycle claim wins.
    always_comb begin
        pend_d = pend_q;
        if (wr_v) begin
            pend_d[wr_idx] = 1'b0;
        end
        if (claim_v) begin
            pend_d[claim_idx] = 1'b1;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Lookups hide a bit the same-cycle write is about to clear, unless re-claimed.
    always_comb begin
        fwd_clr = '0;
        if (BYPASS != 0 && wr_v && !(claim_v && claim_idx == wr_idx)) begin
            fwd_clr[wr_idx] = 1'b1;
        end
    end

    assign rs1_pend = !busy && pend_q[rs1_idx] && !fwd_clr[rs1_idx];
    assign rs2_pend = !busy && pend_q[rs2_idx] && !fwd_clr[rs2_idx];

endmodule

// File: rtl/regfile_mp.sv
// Two-read/one-write register file with write forwarding, pending scoreboard
// and a post-reset clear sequence that zeroes one register per cycle.
module regfile_mp
    import rv_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned NREGS  = NREGS_DEF,
    parameter int unsigned BYPASS = 1,
    localparam int unsigned IW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IW-1:0]   rs1_idx,
    input  logic [IW-1:0]   rs2_idx,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic            rs1_pend,
    output logic            rs2_pend,
    input  logic            we,
    input  logic [IW-1:0]   rd_idx,
    input  logic [XLEN-1:0] rd_data,
    input  logic            claim_en,
    input  logic [IW-1:0]   claim_idx,
    output logic            busy
);

    rf_state_e       state_q;
    rf_state_e       state_d;
    logic [IW-1:0]   clr_cnt_q;
    logic [IW-1:0]   clr_cnt_d;
    logic            clr_we;
    logic            wr_v;
    logic            claim_v;
    logic [XLEN-1:0] regs [NREGS];

    assign busy    = (state_q == RF_CLEAR);
    assign wr_v    = we && !busy && (rd_idx != '0);
    assign claim_v = claim_en && !busy && (claim_idx != '0);

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        clr_we    = 1'b0;
        case (state_q)
            RF_CLEAR: begin
                clr_we = 1'b1;
                if (clr_cnt_q == IW'(NREGS - 1)) begin
                    state_d   = RF_READY;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + IW'(1);
                end
            end
            RF_READY: begin
                state_d = RF_READY;
            end
            default: begin
                state_d = RF_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RF_CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Storage has no reset; the clear sequence is the only zeroing path.
    always_ff @(posedge clk) begin
        if (clr_we) begin
            regs[clr_cnt_q] <= '0;
        end else if (wr_v) begin
            regs[rd_idx] <= rd_data;
        end
    end

    always_comb begin
        rs1_data = '0;
        rs2_data = '0;
        if (!busy && rs1_idx != '0) begin
            rs1_data = (BYPASS != 0 && wr_v && rd_idx == rs1_idx) ? rd_data : regs[rs1_idx];
        end
        if (!busy && rs2_idx != '0) begin
            rs2_data = (BYPASS != 0 && wr_v && rd_idx == rs2_idx) ? rd_data : regs[rs2_idx];
        end
    end

    regfile_sb #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .busy      (busy),
        .wr_v      (wr_v),
        .wr_idx    (rd_idx),
        .claim_v   (claim_v),
        .claim_idx (claim_idx),
        .rs1_idx   (rs1_idx),
        .rs2_idx   (rs2_idx),
        .rs1_pend  (rs1_pend),
        .rs2_pend  (rs2_pend)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized scoreboard bench for regfile_mp (32x32 with forwarding) plus
// directed checks on a 16x64 instance without forwarding.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Instance A: XLEN=32, NREGS=32, BYPASS=1
    logic        a_rst = 1'b1, a_we = 1'b0, a_ce = 1'b0;
    logic [4:0]  a_rd = '0, a_ci = '0, a_i1 = '0, a_i2 = '0;
    logic [31:0] a_wd = '0;
    logic [31:0] a_d1, a_d2;
    logic        a_p1, a_p2, a_busy;

    // Instance B: XLEN=64, NREGS=16, BYPASS=0
    logic        b_rst = 1'b1, b_we = 1'b0, b_ce = 1'b0;
    logic [3:0]  b_rd = '0, b_ci = '0, b_i1 = '0, b_i2 = '0;
    logic [63:0] b_wd = '0;
    logic [63:0] b_d1, b_d2;
    logic        b_p1, b_p2, b_busy;

    regfile_mp #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
        .clk(clk), .rst(a_rst), .rs1_idx(a_i1), .rs2_idx(a_i2),
        .rs1_data(a_d1), .rs2_data(a_d2), .rs1_pend(a_p1), .rs2_pend(a_p2),
        .we(a_we), .rd_idx(a_rd), .rd_data(a_wd),
        .claim_en(a_ce), .claim_idx(a_ci), .busy(a_busy)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .BYPASS(0)) dut_b (
        .clk(clk), .rst(b_rst), .rs1_idx(b_i1), .rs2_idx(b_i2),
        .rs1_data(b_d1), .rs2_data(b_d2), .rs1_pend(b_p1), .rs2_pend(b_p2),
        .we(b_we), .rd_idx(b_rd), .rd_data(b_wd),
        .claim_en(b_ce), .claim_idx(b_ci), .busy(b_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    endtask

    // Reference model of instance A: architectural contents, pending set, busy countdown.
    logic [31:0] mdl_reg  [32];
    bit          mdl_pend [32];
    int          busy_left = 0;
    bit          known     = 1'b0;

    typedef struct {
        logic [31:0] d1, d2;
        logic        p1, p2, busy;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [31:0] exp_data(int i, bit bz, bit wr, int rd, logic [31:0] wd);
        if (bz || i == 0) return 32'h0;
        if (wr && rd == i) return wd;
        return mdl_reg[i];
    endfunction

    function automatic logic exp_pend(int i, bit bz, bit wr, int rd, bit cl, int ci);
        if (bz || i == 0) return 1'b0;
        if (wr && rd == i && !(cl && ci == i)) return 1'b0;
        return mdl_pend[i];
    endfunction

    // One cycle of stimulus on A: drive, predict this cycle's outputs, advance model.
    task automatic cycle_a(input bit r, input bit w, input int rd, input logic [31:0] wd,
                           input bit ce, input int ci, input int i1, input int i2);
        bit   bz, wr, cl;
        exp_t e;
        a_rst = r; a_we = w; a_rd = 5'(rd); a_wd = wd;
        a_ce = ce; a_ci = 5'(ci); a_i1 = 5'(i1); a_i2 = 5'(i2);
        bz = (busy_left > 0);
        wr = !bz && w && rd != 0;
        cl = !bz && ce && ci != 0;
        if (known) begin
            e.busy = bz;
            e.d1   = exp_data(i1, bz, wr, rd, wd);
            e.d2   = exp_data(i2, bz, wr, rd, wd);
            e.p1   = exp_pend(i1, bz, wr, rd, cl, ci);
            e.p2   = exp_pend(i2, bz, wr, rd, cl, ci);
            exp_q.push_back(e);
        end
        if (r) begin
            for (int k = 0; k < 32; k++) begin
                mdl_reg[k]  = 32'h0;
                mdl_pend[k] = 1'b0;
            end
            busy_left = 32;
            known     = 1'b1;
        end else if (bz) begin
            busy_left--;
        end else begin
            if (wr) begin
                mdl_reg[rd]  = wd;
                mdl_pend[rd] = 1'b0;
            end
            if (cl) mdl_pend[ci] = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_a(input int i1, input int i2);
        cycle_a(1'b0, 1'b0, 0, 32'h0, 1'b0, 0, i1, i2);
    endtask

    // Monitor: compare the DUT outputs against the queued prediction mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("a_busy",     64'(a_busy), 64'(e.busy));
                chk("a_rs1_data", 64'(a_d1),   64'(e.d1));
                chk("a_rs2_data", 64'(a_d2),   64'(e.d2));
                chk("a_rs1_pend", 64'(a_p1),   64'(e.p1));
                chk("a_rs2_pend", 64'(a_p2),   64'(e.p2));
            end
        end
    end

    initial begin
        int cnt;
        // Reset pulse, full clear window, then every register reads zero.
        cycle_a(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 0, 0);
        for (int k = 0; k < 34; k++) idle_a(k % 32, 31 - (k % 32));
        for (int k = 0; k < 16; k++) idle_a(2 * k, 2 * k + 1);

        // Forwarding of a write to x5.
        cycle_a(1'b0, 1'b1, 5, 32'hDEADBEEF, 1'b0, 0, 5, 5);
        idle_a(5, 0);

        // x0 is immutable and never pending.
        cycle_a(1'b0, 1'b1, 0, 32'h12345678, 1'b0, 0, 0, 0);
        cycle_a(1'b0, 1'b0, 0, 32'h0, 1'b1, 0, 0, 0);
        idle_a(0, 0);

        // Claim / write interaction on x7.
        cycle_a(1'b0, 1'b0, 0, 32'h0, 1'b1, 7, 0, 7);
        idle_a(0, 7);
        cycle_a(1'b0, 1'b1, 7, 32'h55, 1'b1, 7, 7, 7);
        idle_a(7, 7);
        cycle_a(1'b0, 1'b1, 7, 32'h55, 1'b0, 0, 7, 7);
        idle_a(7, 7);

        // Restart clear mid-sequence; writes during busy are dropped.
        cycle_a(1'b0, 1'b1, 3, 32'hA, 1'b0, 0, 3, 0);
        cycle_a(1'b1, 1'b0, 0, 32'h0, 1'b0, 0, 3, 0);
        for (int k = 0; k < 10; k++) cycle_a(1'b0, 1'b1, 3, $urandom, 1'b1, 3, 3, 3);
        cycle_a(1'b1, 1'b1, 3, 32'hB, 1'b0, 0, 3, 0);
        for (int k = 0; k < 32; k++) cycle_a(1'b0, 1'b1, 3, $urandom, 1'b1, 3, 3, 3);
        idle_a(3, 3);

        // Random traffic with index collisions and occasional resets.
        for (int k = 0; k < 1500; k++) begin
            int rd, ci, i1, i2;
            rd = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            ci = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            i1 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            i2 = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 7) : $urandom_range(0, 31);
            cycle_a($urandom_range(0, 299) == 0, $urandom_range(0, 1) != 0, rd, $urandom,
                    $urandom_range(0, 2) == 0, ci, i1, i2);
        end
        a_rst = 1'b0; a_we = 1'b0; a_ce = 1'b0;
        chk("a_queue_drained", 64'(exp_q.size()), 64'd0);

        // Instance B: clear length with a bounded wait.
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            if (!b_busy) break;
            cnt++;
            @(posedge clk); #1;
        end
        chk("b_clear_len", 64'(cnt), 64'd16);

        // All-ones round trip on x15 and no forwarding on x5.
        b_we = 1'b1; b_rd = 4'd15; b_wd = 64'hFFFF_FFFF_FFFF_FFFF; b_i1 = 4'd15; b_i2 = 4'd5;
        #1;
        chk("b_x15_same_cycle", b_d1, 64'h0);
        @(posedge clk); #1;
        b_rd = 4'd5; b_wd = 64'hDEADBEEF;
        #1;
        chk("b_x15_next_cycle", b_d1, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("b_x5_same_cycle",  b_d2, 64'h0);
        @(posedge clk); #1;
        b_we = 1'b0;
        #1;
        chk("b_x5_next_cycle", b_d2, 64'hDEADBEEF);

        // Pending without forwarding shows the registered bit until the edge.
        b_ce = 1'b1; b_ci = 4'd7; b_i1 = 4'd7;
        @(posedge clk); #1;
        b_ce = 1'b0;
        #1;
        chk("b_pend_after_claim", 64'(b_p1), 64'd1);
        b_we = 1'b1; b_rd = 4'd7; b_wd = 64'h55;
        #1;
        chk("b_pend_write_cycle", 64'(b_p1), 64'd1);
        @(posedge clk); #1;
        b_we = 1'b0;
        #1;
        chk("b_pend_after_write", 64'(b_p1), 64'd0);
        chk("b_x7_data", b_d1, 64'h55);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter XLEN, default 32, data width of each register.
REQ-002 Parameter NREGS, default 32, register count; power of two, 2..64; IW = log2(NREGS).
REQ-003 Parameter BYPASS, default 1, enables same-cycle write-to-read forwarding when 1.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 rs1_idx  input  IW  read port A index.
REQ-007 rs2_idx  input  IW  read port B index.
REQ-008 rs1_data  output  XLEN  read port A data (combinational).
REQ-009 rs2_data  output  XLEN  read port B data (combinational).
REQ-010 rs1_pend  output  1  read port A register awaits a claimed write.
REQ-011 rs2_pend  output  1  read port B register awaits a claimed write.
REQ-012 we  input  1  write enable.
REQ-013 rd_idx  input  IW  write index.
REQ-014 rd_data  input  XLEN  write data.
REQ-015 claim_en  input  1  mark register claim_idx pending (scoreboard set).
REQ-016 claim_idx  input  IW  register to claim.
REQ-017 busy  output  1  clear sequence in progress; all inputs except rst ignored.

Function
REQ-018 Register 0 SHALL always read 0, never be written and never be pending.
REQ-019 Write SHALL commit at the rising edge when we=1, busy=0 and rd_idx!=0.
REQ-020 With BYPASS=1, a read whose index equals rd_idx (nonzero) while we=1 and busy=0 SHALL return rd_data in the same cycle; with BYPASS=0 it SHALL return the old value.
REQ-021 Scoreboard: one pending bit per register; claim_en sets bit claim_idx; committed write clears bit rd_idx.
REQ-022 Claim and write to the same index in the same cycle: pending SHALL end set (new producer wins).
REQ-023 rsN_pend SHALL reflect the registered pending bit; with BYPASS=1 it SHALL read 0 when the same-cycle write clears that index and no same-cycle claim targets it.
REQ-024 Claims to index 0 SHALL be ignored.
REQ-025 FSM states CLEAR and READY; CLEAR writes zero to one register per cycle using counter clr_cnt from 0 to NREGS-1, then moves to READY.
REQ-026 busy SHALL be 1 exactly in CLEAR; while busy, reads SHALL return 0, pend outputs 0, and writes/claims SHALL be dropped.
REQ-027 CLEAR SHALL last exactly NREGS cycles after rst deasserts; busy falls on the edge after clr_cnt=NREGS-1.

Reset
REQ-028 rst=1 SHALL force CLEAR, clr_cnt=0, all pending bits 0, busy=1 on the next edge.
REQ-029 rst asserted mid-CLEAR or in READY SHALL restart the clear sequence from 0.
REQ-030 Register array contents need no reset; zeroing is performed solely by the CLEAR sequence.

Structure
REQ-031 Shared package rv_pkg SHALL hold FSM state enum (RF_CLEAR, RF_READY) and default XLEN/NREGS constants.
REQ-032 Scoreboard SHALL be a sub-module regfile_sb (pending vector, claim/clear, read lookups); array, bypass and FSM stay in regfile_mp.

Verification
REQ-033 Pulse rst 1 cycle -> busy=1 for exactly 32 cycles, then 0; every register then reads 0x00000000.
REQ-034 we=1, rd_idx=5, rd_data=0xDEADBEEF, rs1_idx=5 same cycle -> rs1_data=0xDEADBEEF same cycle (BYPASS=1), old value 0 with BYPASS=0; next cycle 0xDEADBEEF in both.
REQ-035 we=1, rd_idx=0, rd_data=0x12345678 -> rs1_idx=0 reads 0 same and next cycle; claim_idx=0 -> rs1_pend stays 0.
REQ-036 claim x7; next cycle rs2_idx=7 -> rs2_pend=1; write x7=0x55 with claim x7 same cycle -> pend stays 1; write x7 alone -> pend 0 next cycle.
REQ-037 Write x3=0xA after READY, assert rst at clr_cnt=10 of a later clear -> busy restarts, total 32 cycles after rst drop, x3 reads 0, writes during busy dropped.
REQ-038 Parameter sweep XLEN=64, NREGS=16: clear lasts 16 cycles; write/read of 0xFFFF_FFFF_FFFF_FFFF to x15 round-trips.
